// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
package rf_arb_pkg;

  // Default register address and data widths.
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

  // Architectural zero register; writes to it are accepted but never performed.
  localparam int ZERO_REG = 0;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after
// ptr_i (wrapping modulo N) wins. Produces a one-hot grant, its index and
// an any-grant flag. No grant is issued while enable_i is low.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  // Scan requesters starting at the pointer and grant the first active one.
  always_comb begin
    int            sum;
    logic [IW-1:0] idx;
    logic          found;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = 0;
    idx       = '0;
    if (enable_i) begin
      for (int k = 0; k < N; k++) begin
        sum = int'(ptr_i) + k;
        if (sum >= N) sum = sum - N;
        idx = IW'(sum);
        if (!found && req_i[idx]) begin
          gnt_o[idx] = 1'b1;
          gnt_idx_o  = idx;
          found      = 1'b1;
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares the single RF write port among
// NREQ requesters with valid/ready handshakes and round-robin priority.
// The winning write is registered and appears on wb_* one cycle after the
// handshake. Writes to register 0 complete the handshake but keep wb_we low.
// Optional macro RF_WB_FORWARD_EN adds combinational forwarding of the
// in-flight write to two decode read ports (fwd_rs / fwd_rt).
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               wb_we,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      wb_data,
`ifdef RF_WB_FORWARD_EN
  input  logic [AW-1:0]      fwd_rs,
  input  logic [AW-1:0]      fwd_rt,
  output logic               fwd_hit1,
  output logic               fwd_hit2,
  output logic [DW-1:0]      fwd_data,
`endif
  output logic [IW-1:0]      wb_src
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          wb_we_q, wb_we_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [IW-1:0] wb_src_q, wb_src_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            arb_en;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // Grants are suppressed while stalled and while reset is asserted.
  assign arb_en = ~stall & rst_n;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .enable_i  (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // Ready depends only on valid, stall and the pointer, never on payload.
  assign req_ready = gnt;
  assign win_addr  = req_addr[gnt_idx*AW +: AW];
  assign win_data  = req_data[gnt_idx*DW +: DW];

  // Next state: advance the pointer past the winner and capture its write.
  always_comb begin
    ptr_d     = ptr_q;
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_src_d  = wb_src_q;
    if (gnt_any) begin
      ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      wb_we_d   = (win_addr != AW'(ZERO_REG));
      wb_addr_d = win_addr;
      wb_data_d = win_data;
      wb_src_d  = gnt_idx;
    end
  end

  // Pointer and output stage; reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_src_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      ptr_q     <= ptr_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_src_q  <= wb_src_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign wb_src  = wb_src_q;

`ifdef RF_WB_FORWARD_EN
  // Let decode see the value the RF captures only at the next edge.
  assign fwd_hit1 = wb_we_q & (wb_addr_q == fwd_rs) & (fwd_rs != AW'(ZERO_REG));
  assign fwd_hit2 = wb_we_q & (wb_addr_q == fwd_rt) & (fwd_rt != AW'(ZERO_REG));
  assign fwd_data = wb_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. Handshakes observed at posedge push
// the expected write into a scoreboard; the write-port outputs are popped and
// compared at the following negedge. Directed checks cover grant order,
// register-0 writes, stall, async reset and (if enabled) forwarding.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IW   = 2;

  logic               clk;
  logic               rst_n;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               wb_we;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;
  logic [IW-1:0]      wb_src;
`ifdef RF_WB_FORWARD_EN
  logic [AW-1:0]      fwd_rs;
  logic [AW-1:0]      fwd_rt;
  logic               fwd_hit1;
  logic               fwd_hit2;
  logic [DW-1:0]      fwd_data;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
`ifdef RF_WB_FORWARD_EN
    .fwd_rs    (fwd_rs),
    .fwd_rt    (fwd_rt),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data),
`endif
    .wb_src    (wb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] src;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  wb_exp_t last_wb;
  bit      xfer_seen;

  // Reset discards the scoreboard along with the in-flight write.
  always @(negedge rst_n) begin
    sb_q.delete();
    xfer_seen     = 1'b0;
    last_wb.we   = 1'b0;
    last_wb.addr = '0;
    last_wb.data = '0;
    last_wb.src  = '0;
  end

  // Observe handshakes at the active edge and predict the write-port state.
  always @(posedge clk) begin
    wb_exp_t e;
    xfer_seen = 1'b0;
    if (rst_n) begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.addr = req_addr[i*AW +: AW];
          e.data = req_data[i*DW +: DW];
          e.src  = IW'(i);
          e.we   = (e.addr != '0);
          sb_q.push_back(e);
          xfer_seen = 1'b1;
        end
      end
    end
  end

  // Compare the registered write port half a cycle after each edge.
  always @(negedge clk) begin
    wb_exp_t e;
    if (rst_n) begin
      if (xfer_seen) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'd0, 64'd1);
        end else begin
          e = sb_q.pop_front();
          check("sb_we",   64'(wb_we),   64'(e.we));
          check("sb_addr", 64'(wb_addr), 64'(e.addr));
          check("sb_data", 64'(wb_data), 64'(e.data));
          check("sb_src",  64'(wb_src),  64'(e.src));
          last_wb = e;
        end
      end else begin
        check("idle_we",   64'(wb_we),   64'd0);
        check("idle_addr", 64'(wb_addr), 64'(last_wb.addr));
        check("idle_data", 64'(wb_data), 64'(last_wb.data));
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  logic [NREQ-1:0] rr_exp [6];

  initial begin
    rst_n     = 1'b0;
    stall     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
`ifdef RF_WB_FORWARD_EN
    fwd_rs    = '0;
    fwd_rt    = '0;
`endif
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_we",    64'(wb_we),     64'd0);
    check("rst_addr",  64'(wb_addr),   64'd0);
    check("rst_data",  64'(wb_data),   64'd0);
    check("rst_src",   64'(wb_src),    64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);

    // Single request from requester 1.
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1 check("t1_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    check("t1_we",   64'(wb_we),   64'd1);
    check("t1_addr", 64'(wb_addr), 64'd5);
    check("t1_data", 64'(wb_data), 64'hDEADBEEF);
    check("t1_src",  64'(wb_src),  64'd1);
    req_valid = '0;

    // Register-0 write from requester 2 (pointer now 2).
    set_req(2, 5'd0, 32'h1234);
    #1 check("r0_ready", 64'(req_ready), 64'b100);
    @(negedge clk);
    check("r0_we",   64'(wb_we),   64'd0);
    check("r0_data", 64'(wb_data), 64'h1234);
    check("r0_addr", 64'(wb_addr), 64'd0);
    req_valid = '0;
    #1 check("r0_ready_once", 64'(req_ready), 64'd0);

    // All three continuously valid (pointer now 0).
    set_req(0, 5'd1, 32'h100);
    set_req(1, 5'd2, 32'h101);
    set_req(2, 5'd3, 32'h102);
    for (int k = 0; k < 6; k++) begin
      #1 check("rr_ready", 64'(req_ready), 64'(rr_exp[k]));
      @(negedge clk);
      check("rr_we",  64'(wb_we),  64'd1);
      check("rr_src", 64'(wb_src), 64'(k % 3));
    end
    req_valid = '0;

    // Stall: one write in flight, then four frozen cycles (pointer 1 after).
    set_req(0, 5'd9, 32'h99);
    #1 check("st_pre_ready", 64'(req_ready), 64'b001);
    @(negedge clk);
    check("st_inflight_we", 64'(wb_we), 64'd1);
    stall = 1'b1;
    set_req(0, 5'd10, 32'h9A);
    set_req(2, 5'd4,  32'h44);
    for (int k = 0; k < 4; k++) begin
      #1 check("st_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      check("st_we", 64'(wb_we), 64'd0);
    end
    stall = 1'b0;
    #1 check("st_release_ready", 64'(req_ready), 64'b100);
    @(negedge clk);
    check("st_release_src", 64'(wb_src), 64'd2);
    check("st_release_we",  64'(wb_we),  64'd1);

    // Asynchronous reset mid-cycle while a write is on the port.
    set_req(1, 5'd6, 32'h66);
    set_req(2, 5'd7, 32'h77);
    #2 rst_n = 1'b0;
    #1;
    check("ar_we",    64'(wb_we),     64'd0);
    check("ar_addr",  64'(wb_addr),   64'd0);
    check("ar_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ar_ptr0_ready", 64'(req_ready), 64'b001);
    @(negedge clk);
    check("ar_src", 64'(wb_src), 64'd0);
    req_valid = '0;

`ifdef RF_WB_FORWARD_EN
    // Forwarding of the in-flight write (pointer now 1).
    set_req(1, 5'd7, 32'hCAFE);
    @(negedge clk);
    req_valid = '0;
    fwd_rs = 5'd7;
    fwd_rt = 5'd0;
    #1;
    check("fw_hit1", 64'(fwd_hit1), 64'd1);
    check("fw_hit2", 64'(fwd_hit2), 64'd0);
    check("fw_data", 64'(fwd_data), 64'hCAFE);
    fwd_rt = 5'd7;
    #1 check("fw_hit2_rt", 64'(fwd_hit2), 64'd1);
    set_req(2, 5'd0, 32'h55);
    @(negedge clk);
    req_valid = '0;
    fwd_rs = 5'd0;
    fwd_rt = 5'd0;
    #1;
    check("fw_r0_hit1", 64'(fwd_hit1), 64'd0);
    check("fw_r0_hit2", 64'(fwd_hit2), 64'd0);
`endif

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback requesters (ALU result, load data, multi-cycle mul/div).
- Uses a valid/ready handshake per requester and round-robin arbitration.
- Registers the winning write, then drives the register-file write port (RegWrite/WriteReg/WriteData) one cycle later.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- stall  in  1  freeze: no grants while high.
- req_valid  in  NREQ  bit i: requester i has a write pending.
- req_ready  out  NREQ  bit i: requester i granted this cycle (one-hot or zero).
- req_addr  in  NREQ*AW  packed destination registers; slice i = [i*AW +: AW].
- req_data  in  NREQ*DW  packed write data; slice i = [i*DW +: DW].
- wb_we  out  1  to RF RegWrite.
- wb_addr  out  AW  to RF WriteReg.
- wb_data  out  DW  to RF WriteData.
- wb_src  out  $clog2(NREQ)  index of requester whose write is on the port.

Behaviour:
- Reset (rst_n low, async):
  - wb_we=0, wb_addr=0, wb_data=0, wb_src=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst_n low.
- Grant (combinational):
  - If stall=0, scan i = ptr, ptr+1, ... mod NREQ.
  - The first i with req_valid[i]=1 wins; req_ready[i]=1.
  - All other ready bits are 0.
  - req_ready must not depend on req_data or req_addr.
- Handshake: a transfer occurs on a posedge where req_valid[i] & req_ready[i] are both high.
  - The requester drops or changes its payload only after the transfer.
  - valid may assert without waiting for ready. Once asserted, valid holds with a stable payload until the transfer.
- Latency: transfer at edge N → wb_we=1 and wb_addr/wb_data/wb_src equal to the winner's payload during cycle N..N+1. The RF captures it at edge N+1.
- wb_we=0 on any cycle following an edge with no transfer. wb_addr/wb_data hold their previous values when idle.
- Register 0 writes: the handshake completes normally, but wb_we stays 0 for that cycle. wb_addr/wb_data/wb_src still update.
- Pointer update:
  - After a transfer from i: ptr = (i+1) mod NREQ.
  - No transfer: ptr is unchanged.
  - Guarantees that any continuously valid requester is granted within NREQ cycles of stall being low.
- stall=1: no grants. The output stage completes the write already in flight, then wb_we=0. ptr holds.
- Same-address writes from two requesters are serialized in grant order; the last granted value wins in the RF.
- Reset mid-operation: an in-flight write is discarded (wb_we forced 0). Pending requests must be re-presented after reset.

Optional Feature:
- Macro RF_WB_FORWARD_EN.
- Defined: adds the following ports:
  - fwd_rs in AW, fwd_rt in AW.
  - fwd_hit1 out 1, fwd_hit2 out 1, fwd_data out DW.
- Combinational forwarding of the in-flight write:
  - fwd_hit1 = wb_we & (wb_addr==fwd_rs) & (fwd_rs!=0). fwd_hit2 is the same with fwd_rt.
  - fwd_data = wb_data.
  - Lets decode see a value that the RF will only capture at the next edge.
- Undefined: the ports are absent and there is no forwarding logic. Consumers must stall one cycle on a read-after-write to the same register.

Decomposition:
- Package rf_arb_pkg holds:
  - Default AW/DW constants.
  - A function for the NREQ index width.
  - Localparam ZERO_REG=0.
- One sub-module, rr_arbiter (parameter N):
  - Inputs: req[N], ptr, enable.
  - Outputs: one-hot gnt[N], gnt_idx, any.
  - Purely combinational.
- rf_wb_arbiter owns ptr, the output register, and the forwarding logic.

Test Plan:
- Reset release → all wb_* = 0, req_ready = 0. First single request valid[1], addr=5, data=0xDEADBEEF → ready[1] the same cycle. Next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, wb_src=1.
- All three valid continuously with distinct addresses 1/2/3 → grant order 0,1,2,0,1,2. wb_src follows the same sequence one cycle late. wb_we stays 1 every cycle.
- Request addr=0, data=0x1234 → ready pulses once, wb_we=0 the next cycle, wb_data=0x1234.
- stall=1 while valid[0],valid[2] held for 4 cycles → req_ready=0 throughout, wb_we=0 after the in-flight write. Release stall → grant goes to the index ≥ ptr.
- Assert rst_n=0 asynchronously mid-cycle while wb_we=1 → wb_we drops immediately without waiting for clk, ptr=0.
- RF_WB_FORWARD_EN: in-flight write addr=7, data=0xCAFE; fwd_rs=7, fwd_rt=0 → fwd_hit1=1, fwd_hit2=0, fwd_data=0xCAFE. For a write to addr=0 with fwd_rs=0 → fwd_hit1=0.
